// File: rtl/tactile_pkg.sv
// Shared types and width helpers for the tactile centroid block.
package tactile_pkg;

    localparam int DATA_W_DEF = 12;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DIV_X  = 2'd1,
        DIV_Y  = 2'd2,
        UPDATE = 2'd3
    } state_t;

    function automatic int idx_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    function automatic int weight_sum_width(input int data_w);
        return data_w + 8;
    endfunction

    function automatic int index_sum_width(input int data_w);
        return data_w + 12;
    endfunction

    function automatic int quot_width(input int sw_count, input int frac);
        return idx_width(sw_count) + frac;
    endfunction

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle over QW cycles.
// The quotient is assumed to fit in QW bits; otherwise the result saturates meaninglessly.
module serial_divider
    import tactile_pkg::*;
#(
    parameter int DVD_W = 28,
    parameter int DVS_W = 20,
    parameter int QW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [QW-1:0]    quotient
);

    localparam int SH_W  = DVS_W + QW - 1;
    localparam int CMP_W = (DVD_W > SH_W) ? DVD_W : SH_W;
    localparam int CNT_W = idx_width(QW);

    logic [DVD_W-1:0] rem, rem_cur, rem_nxt;
    logic [SH_W-1:0]  dsh, dsh_cur;
    logic [QW-1:0]    q, q_cur;
    logic [CNT_W-1:0] cnt;
    logic             ge;

    // The start edge already resolves the top quotient bit, so QW edges in total.
    always_comb begin
        rem_cur = rem;
        dsh_cur = dsh;
        q_cur   = q;
        if (start) begin
            rem_cur = dividend;
            dsh_cur = SH_W'(divisor) << (QW - 1);
            q_cur   = '0;
        end
        ge      = CMP_W'(rem_cur) >= CMP_W'(dsh_cur);
        rem_nxt = ge ? rem_cur - DVD_W'(dsh_cur) : rem_cur;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem  <= '0;
            dsh  <= '0;
            q    <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start || busy) begin
                rem <= rem_nxt;
                dsh <= dsh_cur >> 1;
                q   <= {q_cur[QW-2:0], ge};
            end
            if (start) begin
                busy <= 1'b1;
                cnt  <= CNT_W'(1);
            end else if (busy) begin
                if (cnt == CNT_W'(QW - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign quotient = q;

endmodule

// File: rtl/tactile_centroid.sv
// Per-frame centre-of-mass of a tactile grid, converted to screen pixels.
module tactile_centroid
    import tactile_pkg::*;
#(
    parameter int SW_WIRE_CNT = 16,
    parameter int RD_WIRE_CNT = 16,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int NOISE_FLOOR = 8,
    parameter int MIN_WEIGHT  = 16,
    parameter int FRAC        = 4,
    parameter int CELL_PX     = 32,
    parameter int X_ORIGIN    = 64,
    parameter int Y_ORIGIN    = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           sample_valid,
    output logic                           sample_ready,
    input  logic [DATA_W-1:0]              sample_data,
    input  logic [$clog2(SW_WIRE_CNT)-1:0] sample_sw,
    input  logic [$clog2(RD_WIRE_CNT)-1:0] sample_rd,
    input  logic                           sample_last,
    output logic [10:0]                    x_com,
    output logic [9:0]                     y_com,
    output logic                           touch,
    output logic                           com_valid
);

    localparam int SUM_W   = weight_sum_width(DATA_W);
    localparam int SUMI_W  = index_sum_width(DATA_W);
    localparam int QW      = quot_width(SW_WIRE_CNT, FRAC);
    localparam int DVD_W   = SUMI_W + FRAC;
    localparam int CELL_SH = $clog2(CELL_PX);
    localparam int PX_W    = QW + CELL_SH;

    state_t            state;
    logic [SUM_W-1:0]  acc_w;
    logic [SUMI_W-1:0] acc_wx, acc_wy;
    logic [QW-1:0]     qx;
    logic [DATA_W-1:0] w;
    logic              accept;
    logic              div_start, div_busy, div_done;
    logic [DVD_W-1:0]  div_dividend;
    logic [QW-1:0]     div_quotient;
    logic [PX_W-1:0]   px_x, px_y;
    logic [10:0]       x_next;
    logic [9:0]        y_next;

    assign sample_ready = (state == ACCUM);
    assign accept       = sample_valid && sample_ready;
    assign w = (sample_data > DATA_W'(NOISE_FLOOR)) ? sample_data - DATA_W'(NOISE_FLOOR) : '0;

    // One divider serves both axes: the x result's done cycle immediately launches y.
    assign div_start    = (state == DIV_X) && !div_busy;
    assign div_dividend = div_done ? (DVD_W'(acc_wy) << FRAC) : (DVD_W'(acc_wx) << FRAC);

    serial_divider #(
        .DVD_W (DVD_W),
        .DVS_W (SUM_W),
        .QW    (QW)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (acc_w),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    assign px_x   = PX_W'(qx) << CELL_SH;
    assign px_y   = PX_W'(div_quotient) << CELL_SH;
    assign x_next = 11'(X_ORIGIN) + 11'(px_x >> FRAC);
    assign y_next = 10'(Y_ORIGIN) + 10'(px_y >> FRAC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc_w     <= '0;
            acc_wx    <= '0;
            acc_wy    <= '0;
            qx        <= '0;
            x_com     <= 11'(X_ORIGIN);
            y_com     <= 10'(Y_ORIGIN);
            touch     <= 1'b0;
            com_valid <= 1'b0;
        end else begin
            com_valid <= 1'b0;
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc_w  <= acc_w + SUM_W'(w);
                        acc_wx <= acc_wx + SUMI_W'(w) * SUMI_W'(sample_sw);
                        acc_wy <= acc_wy + SUMI_W'(w) * SUMI_W'(sample_rd);
                        if (sample_last) state <= DIV_X;
                    end
                end
                DIV_X: begin
                    if (div_done) begin
                        qx    <= div_quotient;
                        state <= DIV_Y;
                    end
                end
                DIV_Y: begin
                    if (div_done) begin
                        if (acc_w >= SUM_W'(MIN_WEIGHT)) begin
                            x_com <= x_next;
                            y_com <= y_next;
                            touch <= 1'b1;
                        end else begin
                            touch <= 1'b0;
                        end
                        com_valid <= 1'b1;
                        state     <= UPDATE;
                    end
                end
                UPDATE: begin
                    acc_w  <= '0;
                    acc_wx <= '0;
                    acc_wy <= '0;
                    state  <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_tactile_centroid.sv
// Frame-level bench: centroid computed from summed weights with plain integer arithmetic.
module tb_tactile_centroid;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [11:0] sample_data = '0;
    logic [3:0]  sample_sw = '0;
    logic [3:0]  sample_rd = '0;
    logic        sample_last = 1'b0;
    logic [10:0] x_com;
    logic [9:0]  y_com;
    logic        touch;
    logic        com_valid;

    typedef struct {
        int data;
        int sw;
        int rd;
    } smp_t;

    smp_t frame_q[$];
    int   grid[16][16];
    int   errors = 0;
    int   checks = 0;
    int   ref_x = 64;
    int   ref_y = 64;
    bit   ref_touch = 1'b0;
    bit   gap_en = 1'b0;

    tactile_centroid #(
        .SW_WIRE_CNT (16),
        .RD_WIRE_CNT (16),
        .DATA_W      (12),
        .NOISE_FLOOR (8),
        .MIN_WEIGHT  (16),
        .FRAC        (4),
        .CELL_PX     (32),
        .X_ORIGIN    (64),
        .Y_ORIGIN    (64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_data  (sample_data),
        .sample_sw    (sample_sw),
        .sample_rd    (sample_rd),
        .sample_last  (sample_last),
        .x_com        (x_com),
        .y_com        (y_com),
        .touch        (touch),
        .com_valid    (com_valid)
    );

    always #5 clk = ~clk;

    task automatic clear_grid(input int val);
        for (int s = 0; s < 16; s++)
            for (int r = 0; r < 16; r++)
                grid[s][r] = val;
    endtask

    task automatic load_grid();
        frame_q.delete();
        for (int r = 0; r < 16; r++)
            for (int s = 0; s < 16; s++)
                frame_q.push_back('{data: grid[s][r], sw: s, rd: r});
    endtask

    // Centre of mass from first principles: sum of weights, sum of index*weight.
    task automatic model_frame();
        int sw_sum, sx, sy, wt, qx, qy;
        sw_sum = 0; sx = 0; sy = 0;
        foreach (frame_q[i]) begin
            wt = (frame_q[i].data > 8) ? frame_q[i].data - 8 : 0;
            sw_sum += wt;
            sx += wt * frame_q[i].sw;
            sy += wt * frame_q[i].rd;
        end
        if (sw_sum >= 16) begin
            qx = (sx * 16) / sw_sum;
            qy = (sy * 16) / sw_sum;
            ref_x = 64 + (qx * 32) / 16;
            ref_y = 64 + (qy * 32) / 16;
            ref_touch = 1'b1;
        end else begin
            ref_touch = 1'b0;
        end
    endtask

    // Called at a negedge; returns at the negedge after the final accept edge.
    task automatic drive_frame(input bit mark_last, input bit hold);
        int t;
        for (int i = 0; i < frame_q.size(); i++) begin
            if (gap_en && $urandom_range(0, 5) == 0) begin
                sample_valid = 1'b0;
                @(negedge clk);
            end
            sample_valid = 1'b1;
            sample_data  = 12'(frame_q[i].data);
            sample_sw    = 4'(frame_q[i].sw);
            sample_rd    = 4'(frame_q[i].rd);
            sample_last  = mark_last && (i == frame_q.size() - 1);
            t = 0;
            while (sample_ready !== 1'b1 && t < 40) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (t == 40) begin
                errors++;
                $display("FAIL accept_timeout: sample_ready=%b for 40 cycles, want 1", sample_ready);
                sample_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        if (hold) begin
            sample_valid = 1'b1;
            sample_data  = 12'hFFF;
            sample_sw    = 4'($urandom_range(0, 15));
            sample_rd    = 4'($urandom_range(0, 15));
            sample_last  = 1'b1;
        end else begin
            sample_valid = 1'b0;
            sample_last  = 1'b0;
        end
    endtask

    task automatic check_result(input string tag);
        int old_x, old_y;
        old_x = ref_x;
        old_y = ref_y;
        model_frame();
        checks++;
        if (sample_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_e0: got %b want 0", tag, sample_ready);
        end
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            checks++;
            if (com_valid !== (k == 17)) begin
                errors++;
                $display("FAIL %s com_valid_e%0d: got %b want %b", tag, k, com_valid, (k == 17));
            end
            checks++;
            if (sample_ready !== (k >= 18)) begin
                errors++;
                $display("FAIL %s ready_e%0d: got %b want %b", tag, k, sample_ready, (k >= 18));
            end
            if (k == 16) begin
                checks++;
                if (x_com !== 11'(old_x) || y_com !== 10'(old_y)) begin
                    errors++;
                    $display("FAIL %s early_update: got %0d/%0d want %0d/%0d", tag, x_com, y_com, old_x, old_y);
                end
            end
            if (k == 17) begin
                checks++;
                if (x_com !== 11'(ref_x)) begin
                    errors++;
                    $display("FAIL %s x_com: got %0d want %0d", tag, x_com, ref_x);
                end
                checks++;
                if (y_com !== 10'(ref_y)) begin
                    errors++;
                    $display("FAIL %s y_com: got %0d want %0d", tag, y_com, ref_y);
                end
                checks++;
                if (touch !== ref_touch) begin
                    errors++;
                    $display("FAIL %s touch: got %b want %b", tag, touch, ref_touch);
                end
            end
            if (k == 18) sample_valid = 1'b0;
        end
        sample_last = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (x_com !== 11'd64 || y_com !== 10'd64 || touch !== 1'b0 || com_valid !== 1'b0 || sample_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: got x=%0d y=%0d t=%b v=%b r=%b want 64 64 0 0 1",
                     x_com, y_com, touch, com_valid, sample_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_cell();
        clear_grid(0);
        grid[5][3] = 100;
        load_grid();
        drive_frame(1'b1, 1'b0);
        check_result("single_cell");
    endtask

    task automatic test_pair();
        clear_grid(0);
        grid[2][7] = 58;
        grid[3][7] = 58;
        load_grid();
        drive_frame(1'b1, 1'b0);
        check_result("pair");
    endtask

    task automatic test_noise_floor();
        test_single_cell();
        clear_grid(8);
        load_grid();
        drive_frame(1'b1, 1'b0);
        check_result("noise_floor");
    endtask

    task automatic test_back_to_back();
        clear_grid(0);
        grid[5][3] = 100;
        load_grid();
        drive_frame(1'b1, 1'b1);
        check_result("hold_valid");
        drive_frame(1'b1, 1'b0);
        check_result("after_hold");
    endtask

    task automatic test_reset_mid_divide();
        frame_q.delete();
        for (int i = 0; i < 5; i++) frame_q.push_back('{data: 4000, sw: 15, rd: 0});
        drive_frame(1'b0, 1'b0);
        clear_grid(0);
        grid[12][12] = 900;
        load_grid();
        drive_frame(1'b1, 1'b0);
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (x_com !== 11'd64 || y_com !== 10'd64 || touch !== 1'b0 || com_valid !== 1'b0 || sample_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_div: got x=%0d y=%0d t=%b v=%b r=%b want 64 64 0 0 1",
                     x_com, y_com, touch, com_valid, sample_ready);
        end
        ref_x = 64;
        ref_y = 64;
        ref_touch = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_grid(0);
        grid[5][3] = 100;
        load_grid();
        drive_frame(1'b1, 1'b0);
        check_result("after_reset");
    endtask

    task automatic test_min_weight();
        clear_grid(0);
        grid[9][11] = 23;
        load_grid();
        drive_frame(1'b1, 1'b0);
        check_result("below_min");
        grid[9][11] = 24;
        load_grid();
        drive_frame(1'b1, 1'b0);
        check_result("at_min");
    endtask

    task automatic test_single_sample();
        frame_q.delete();
        frame_q.push_back('{data: 500, sw: 14, rd: 1});
        drive_frame(1'b1, 1'b0);
        check_result("single_sample");
    endtask

    task automatic test_random();
        gap_en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < 16; s++)
                for (int r = 0; r < 16; r++)
                    grid[s][r] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4095))
                                                             : int'($urandom_range(0, 12));
            load_grid();
            drive_frame(1'b1, 1'b0);
            check_result("random_full");
        end
        for (int f = 0; f < 4; f++) begin
            frame_q.delete();
            for (int i = 0; i < int'($urandom_range(1, 12)); i++)
                frame_q.push_back('{data: int'($urandom_range(0, 4095)),
                                    sw: int'($urandom_range(0, 15)),
                                    rd: int'($urandom_range(0, 15))});
            drive_frame(1'b1, 1'b0);
            check_result("random_short");
        end
        gap_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_cell();
        test_pair();
        test_noise_floor();
        test_back_to_back();
        test_reset_mid_divide();
        test_min_weight();
        test_single_sample();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
